// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios input-capture PIO: register word addresses
// and edge-capture mode encodings.
package nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_COUNT = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    typedef enum int unsigned {
        EDGE_RISE = 0,
        EDGE_FALL = 1,
        EDGE_ANY  = 2
    } edge_mode_e;

endpackage

// File: rtl/nios_pio_sync.sv
// Multi-stage flop synchronizer for an asynchronous input bus; q is the
// output of the last stage.
module nios_pio_sync #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/nios_system_pio_in_capture.sv
// Avalon-MM input PIO: synchronized input, sticky per-bit edge capture with
// W1C, change counter, interrupt mask and registered level irq.
module nios_system_pio_in_capture
    import nios_pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam int unsigned PRIME_TERM = SYNC_STAGES + 1;
    localparam int unsigned PRIME_W    = $clog2(PRIME_TERM + 1);

    logic [DATA_WIDTH-1:0] sync;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] det;
    logic [DATA_WIDTH-1:0] edge_cap;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] wdata;
    logic [CNT_WIDTH-1:0]  count;
    logic [PRIME_W-1:0]    prime_cnt;
    logic                  primed;
    logic                  inc;
    logic                  wr;
    logic                  wr_count;
    logic                  wr_mask;
    logic                  wr_edge;
    logic [31:0]           rd_next;
    logic                  unused_bits;

    nios_pio_sync #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync)
    );

    assign wdata       = writedata[DATA_WIDTH-1:0];
    assign unused_bits = ^writedata;
    assign wr          = chipselect & ~write_n;
    assign wr_count    = wr && (address == ADDR_COUNT);
    assign wr_mask     = wr && (address == ADDR_MASK);
    assign wr_edge     = wr && (address == ADDR_EDGE);

    // Capture stays off until the synchronizer and prev have flushed the
    // post-reset transition, so a held-high input never looks like an edge.
    assign primed = (prime_cnt == PRIME_W'(PRIME_TERM));
    assign inc    = primed && (sync != prev);

    always_comb begin
        det = '0;
        if (primed) begin
            if (EDGE_TYPE == EDGE_FALL) begin
                det = ~sync & prev;
            end else if (EDGE_TYPE == EDGE_ANY) begin
                det = sync ^ prev;
            end else begin
                det = sync & ~prev;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
            prev      <= '0;
        end else begin
            prev <= sync;
            if (!primed) begin
                prime_cnt <= prime_cnt + PRIME_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_count) begin
                count <= inc ? CNT_WIDTH'(1) : '0;
            end else if (inc) begin
                count <= count + CNT_WIDTH'(1);
            end
            if (wr_mask) begin
                irq_mask <= wdata;
            end
            // A new edge in the same cycle as its W1C keeps the bit set.
            edge_cap <= (edge_cap & ~(wr_edge ? wdata : '0)) | det;
            irq      <= |(edge_cap & irq_mask);
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:  rd_next[DATA_WIDTH-1:0] = sync;
            ADDR_COUNT: rd_next[CNT_WIDTH-1:0]  = count;
            ADDR_MASK:  rd_next[DATA_WIDTH-1:0] = irq_mask;
            default:    rd_next[DATA_WIDTH-1:0] = edge_cap;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule
